// File: rtl/regression_inference_mlane_if.sv
// Memory-bus, control and result signals of the multi-lane regression inference core.
// master = the core, slave = memories/control/result consumer.
interface regression_inference_mlane_if #(
  parameter int N_INPUTS  = 784,
  parameter int N_CLASSES = 10,
  parameter int LANES     = 2,
  parameter int W_W       = 8,
  parameter int ACC_W     = 32
);
  localparam int PASSES = (N_CLASSES + LANES - 1) / LANES;
  localparam int WA_W   = (PASSES * N_INPUTS > 1) ? $clog2(PASSES * N_INPUTS) : 1;
  localparam int CLS_W  = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam int IA_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  logic [WA_W-1:0]        weight_addr;
  logic [LANES*W_W-1:0]   weight_data;
  logic [CLS_W-1:0]       bias_addr;
  logic [ACC_W-1:0]       bias_data;
  logic [IA_W-1:0]        input_addr;
  logic [7:0]             input_pixel;
  logic                   weights_ready;
  logic                   start_inference;
  logic [CLS_W-1:0]       predicted_digit;
  logic [ACC_W-1:0]       max_score;
  logic                   inference_done;
  logic                   busy;

  modport master (
    output weight_addr, bias_addr, input_addr,
    output predicted_digit, max_score, inference_done, busy,
    input  weight_data, bias_data, input_pixel, weights_ready, start_inference
  );

  modport slave (
    input  weight_addr, bias_addr, input_addr,
    input  predicted_digit, max_score, inference_done, busy,
    output weight_data, bias_data, input_pixel, weights_ready, start_inference
  );
endinterface

// File: rtl/regression_inference_mlane.sv
// Multi-lane linear classifier: LANES class scores per pass over the image, then argmax.
// Optional macro SCORE_READ_EN adds a readable register file of all final class scores.
module regression_inference_mlane #(
  parameter int N_INPUTS  = 784,
  parameter int N_CLASSES = 10,
  parameter int LANES     = 2,
  parameter int W_W       = 8,
  parameter int ACC_W     = 32,
  localparam int PASSES   = (N_CLASSES + LANES - 1) / LANES,
  localparam int CLS_W    = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic clk,
  input  logic rst,
  regression_inference_mlane_if.master bus
`ifdef SCORE_READ_EN
  ,
  input  logic [CLS_W-1:0] score_rd_addr,
  output logic [ACC_W-1:0] score_rd_data
`endif
);
  localparam int WA_W = (PASSES * N_INPUTS > 1) ? $clog2(PASSES * N_INPUTS) : 1;
  localparam int IA_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int PC_W = $clog2(PASSES + 1);
  localparam int K_W  = $clog2(LANES + 2);
  localparam int CI_W = $clog2(PASSES * LANES + LANES + 1);
  localparam int PW   = W_W + 9;

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_BIAS, S_DONE} state_e;
  state_e state_q, state_d;

  logic [IA_W-1:0]         i_q;
  logic [WA_W-1:0]         wbase_q;
  logic [PC_W-1:0]         pass_q;
  logic [CI_W-1:0]         cbase_q;
  logic [K_W-1:0]          k_q;
  logic                    mac_vld_q;
  logic                    bias_vld_q;
  logic [CI_W-1:0]         bias_cls_q;
  logic [K_W-1:0]          bias_lane_q;
  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] run_max_q;
  logic [CLS_W-1:0]        run_idx_q;
  logic signed [ACC_W-1:0] max_q;
  logic [CLS_W-1:0]        pred_q;
  logic                    done_q;
  logic                    busy_q;

  logic                    start_ok;
  logic                    last_i;
  logic                    last_k;
  logic                    last_pass;
  logic                    bias_issue;
  logic [CI_W-1:0]         cur_cls;
  logic signed [ACC_W-1:0] sel_acc;
  logic signed [ACC_W-1:0] score;
  logic signed [ACC_W-1:0] prod [LANES];

  // A start coinciding with the done pulse is dropped; IDLE accepts one cycle later.
  assign start_ok   = (state_q == S_IDLE) && bus.start_inference && bus.weights_ready && !done_q;
  assign last_i     = (i_q == IA_W'(N_INPUTS - 1));
  assign last_k     = (k_q == K_W'(LANES));
  assign last_pass  = (pass_q == PC_W'(PASSES - 1));
  assign cur_cls    = cbase_q + CI_W'(k_q);
  assign bias_issue = (state_q == S_BIAS) && (k_q < K_W'(LANES)) && (cur_cls < CI_W'(N_CLASSES));
  assign score      = sel_acc + $signed(bus.bias_data);

  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      prod[j] = ACC_W'(PW'(signed'({1'b0, bus.input_pixel})) *
                       PW'(signed'(bus.weight_data[j*W_W +: W_W])));
    end
  end

  always_comb begin
    sel_acc = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (bias_lane_q == K_W'(j)) sel_acc = acc_q[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    bus.input_addr      = i_q;
    bus.weight_addr     = wbase_q + WA_W'(i_q);
    bus.bias_addr       = bias_issue ? CLS_W'(cur_cls) : '0;
    bus.predicted_digit = pred_q;
    bus.max_score       = max_q;
    bus.inference_done  = done_q;
    bus.busy            = busy_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_MAC;
      S_MAC:   if (last_i) state_d = S_DRAIN;
      S_DRAIN: state_d = S_BIAS;
      S_BIAS:  if (last_k) state_d = last_pass ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q         <= '0;
      wbase_q     <= '0;
      pass_q      <= '0;
      cbase_q     <= '0;
      k_q         <= '0;
      mac_vld_q   <= 1'b0;
      bias_vld_q  <= 1'b0;
      bias_cls_q  <= '0;
      bias_lane_q <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      max_q       <= '0;
      pred_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned j = 0; j < LANES; j++) acc_q[j] <= '0;
    end else begin
      mac_vld_q   <= (state_q == S_MAC);
      bias_vld_q  <= bias_issue;
      bias_cls_q  <= cur_cls;
      bias_lane_q <= k_q;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            i_q     <= '0;
            wbase_q <= '0;
            pass_q  <= '0;
            cbase_q <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            for (int unsigned j = 0; j < LANES; j++) acc_q[j] <= '0;
          end
        end
        S_MAC: i_q <= last_i ? '0 : i_q + IA_W'(1);
        S_BIAS: begin
          if (last_k) begin
            k_q <= '0;
            for (int unsigned j = 0; j < LANES; j++) acc_q[j] <= '0;
            if (last_pass) begin
              pass_q  <= '0;
              wbase_q <= '0;
              cbase_q <= '0;
            end else begin
              pass_q  <= pass_q + PC_W'(1);
              wbase_q <= wbase_q + WA_W'(N_INPUTS);
              cbase_q <= cbase_q + CI_W'(LANES);
            end
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          pred_q <= run_idx_q;
          max_q  <= run_max_q;
        end
        default: ;
      endcase
      // Memory data lags the address by one cycle, so accumulate on the cycle after MAC issued it.
      if (mac_vld_q) begin
        for (int unsigned j = 0; j < LANES; j++) acc_q[j] <= acc_q[j] + prod[j];
      end
      if (bias_vld_q && ((bias_cls_q == '0) || (score > run_max_q))) begin
        run_max_q <= score;
        run_idx_q <= CLS_W'(bias_cls_q);
      end
    end
  end

`ifdef SCORE_READ_EN
  logic [ACC_W-1:0] score_q [N_CLASSES];
  logic [ACC_W-1:0] rd_d;
  logic [ACC_W-1:0] rd_q;

  always_comb begin
    rd_d = '0;
    for (int unsigned c = 0; c < N_CLASSES; c++) begin
      if (score_rd_addr == CLS_W'(c)) rd_d = score_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      for (int unsigned c = 0; c < N_CLASSES; c++) score_q[c] <= '0;
    end else begin
      rd_q <= rd_d;
      for (int unsigned c = 0; c < N_CLASSES; c++) begin
        if (bias_vld_q && (bias_cls_q == CI_W'(c))) score_q[c] <= score;
      end
    end
  end

  assign score_rd_data = rd_q;
`endif
endmodule

// File: tb/tb_regression_inference_mlane.sv
// Scoreboard bench: LANES=2 and LANES=4 instances fed by mock BRAMs with directed weight patterns.
module tb_regression_inference_mlane;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   mode = 1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regression_inference_mlane_if bus2 ();
  regression_inference_mlane_if #(.LANES(4)) bus4 ();

`ifdef SCORE_READ_EN
  logic [3:0]  rd_addr2 = '0;
  logic [31:0] rd_data2;
  logic [3:0]  rd_addr4 = '0;
  logic [31:0] rd_data4;
`endif

  regression_inference_mlane u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef SCORE_READ_EN
    , .score_rd_addr(rd_addr2), .score_rd_data(rd_data2)
`endif
  );

  regression_inference_mlane #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
`ifdef SCORE_READ_EN
    , .score_rd_addr(rd_addr4), .score_rd_data(rd_data4)
`endif
  );

  // Mock weights: mode 1 -> W[2]=+10 else -10; modes 2/3 -> all zero.
  function automatic logic [15:0] wword2(input int addr, input int m);
    logic [15:0] r;
    int c;
    r = '0;
    for (int j = 0; j < 2; j++) begin
      c = (addr / 784) * 2 + j;
      if (m == 1) r[j*8 +: 8] = (c == 2) ? 8'sd10 : -8'sd10;
    end
    return r;
  endfunction

  // LANES=4: padding lanes of pass 2 return +100, W[9]=+1, others 0.
  function automatic logic [31:0] wword4(input int addr);
    logic [31:0] r;
    int p;
    r = '0;
    p = addr / 784;
    for (int j = 0; j < 4; j++) begin
      if (p == 2 && j >= 2)       r[j*8 +: 8] = 8'sd100;
      else if (p * 4 + j == 9)    r[j*8 +: 8] = 8'sd1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bus2.weight_data <= wword2(int'(bus2.weight_addr), mode);
    bus2.bias_data   <= (mode == 2 && bus2.bias_addr == 4'd7) ? 32'd5 : 32'd0;
    bus2.input_pixel <= (mode == 1) ? 8'd10 : 8'd1;
    bus4.weight_data <= wword4(int'(bus4.weight_addr));
    bus4.bias_data   <= '0;
    bus4.input_pixel <= 8'd1;
  end

  typedef struct {
    int digit;
    int score;
    int lat;
    int acc;
  } exp_t;
  exp_t q2[$];
  exp_t q4[$];
  int busy_hi2 = 0;
  int busy_hi4 = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse and checks result, latency and busy span.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_hi2 = 0;
        busy_hi4 = 0;
      end else begin
        if (bus2.inference_done) begin
          if (q2.size() == 0) chk("unexpected_done2", 1, 0);
          else begin
            e = q2.pop_front();
            chk("digit2", longint'(bus2.predicted_digit), e.digit);
            chk("score2", longint'($signed(bus2.max_score)), e.score);
            chk("latency2", cyc - e.acc, e.lat);
            chk("busy_drop2", bus2.busy, 0);
            chk("busy_span2", busy_hi2, e.lat);
          end
          busy_hi2 = 0;
        end else if (bus2.busy) busy_hi2++;
        if (bus4.inference_done) begin
          if (q4.size() == 0) chk("unexpected_done4", 1, 0);
          else begin
            e = q4.pop_front();
            chk("digit4", longint'(bus4.predicted_digit), e.digit);
            chk("score4", longint'($signed(bus4.max_score)), e.score);
            chk("latency4", cyc - e.acc, e.lat);
            chk("busy_drop4", bus4.busy, 0);
            chk("busy_span4", busy_hi4, e.lat);
          end
          busy_hi4 = 0;
        end else if (bus4.busy) busy_hi4++;
      end
    end
  end

  task automatic run2(input int m, input bit push, input int d, input int s);
    exp_t e;
    @(negedge clk);
    mode = m;
    bus2.start_inference = 1'b1;
    @(negedge clk);
    bus2.start_inference = 1'b0;
    if (push) begin
      e.digit = d; e.score = s; e.lat = 3941; e.acc = cyc;
      q2.push_back(e);
    end
  endtask

  task automatic wait_all(input int budget);
    int n;
    n = 0;
    while ((q2.size() + q4.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((q2.size() + q4.size()) != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: %0d results still pending after %0d cycles", q2.size() + q4.size(), budget);
      q2.delete();
      q4.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digit2"}, bus2.predicted_digit, 0);
    chk({tag, "_score2"}, bus2.max_score, 0);
    chk({tag, "_done2"},  bus2.inference_done, 0);
    chk({tag, "_busy2"},  bus2.busy, 0);
    chk({tag, "_waddr2"}, bus2.weight_addr, 0);
    chk({tag, "_iaddr2"}, bus2.input_addr, 0);
    chk({tag, "_baddr2"}, bus2.bias_addr, 0);
    chk({tag, "_busy4"},  bus4.busy, 0);
  endtask

  initial begin
    exp_t e;
    bus2.start_inference = 1'b0;
    bus2.weights_ready   = 1'b1;
    bus4.start_inference = 1'b0;
    bus4.weights_ready   = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    run2(1, 1'b1, 2, 78400);
    wait_all(5000);

`ifdef SCORE_READ_EN
    for (int a = 0; a < 11; a++) begin
      rd_addr2 = (a == 10) ? 4'd15 : 4'(a);
      @(negedge clk);
      chk($sformatf("score_rd[%0d]", rd_addr2), longint'($signed(rd_data2)),
          (a == 10) ? 0 : ((a == 2) ? 78400 : -78400));
    end
`endif

    run2(2, 1'b1, 7, 5);
    wait_all(5000);
    run2(3, 1'b1, 0, 0);
    wait_all(5000);

    // Start with memories not ready is ignored.
    @(negedge clk);
    bus2.weights_ready = 1'b0;
    run2(1, 1'b0, 0, 0);
    chk("nready_busy", bus2.busy, 0);
    repeat (20) @(negedge clk);
    chk("nready_busy_later", bus2.busy, 0);
    bus2.weights_ready = 1'b1;

    // Second start while busy is ignored; ready drop mid-run has no effect.
    run2(1, 1'b1, 2, 78400);
    repeat (99) @(negedge clk);
    bus2.start_inference = 1'b1;
    @(negedge clk);
    bus2.start_inference = 1'b0;
    bus2.weights_ready = 1'b0;
    repeat (50) @(negedge clk);
    bus2.weights_ready = 1'b1;
    wait_all(5000);
    repeat (200) @(negedge clk);

    // Reset 500 cycles into a run aborts it without a done pulse.
    run2(2, 1'b0, 0, 0);
    repeat (499) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("abort");
    repeat (4000) @(negedge clk);
    run2(2, 1'b1, 7, 5);
    wait_all(5000);

    // LANES=4: padding lanes must never win.
    @(negedge clk);
    bus4.start_inference = 1'b1;
    @(negedge clk);
    bus4.start_inference = 1'b0;
    e.digit = 9; e.score = 784; e.lat = 2371; e.acc = cyc;
    q4.push_back(e);
    wait_all(3000);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
